axi_lite_master: RTL and testbench
==================================

# axi_lite_master

Single-outstanding AXI4-Lite initiator that turns one-word read/write commands from a simple valid/ready command port into AXI4-Lite transactions and returns the result on a response port. It sits between control logic such as a test sequencer or a configuration loader and any AXI4-Lite slave register map. It is the requesting end of the same bus the team's register-map slaves respond on.

## Interface
- TIMEOUT_CYCLES, 255: wait-cycle limit per transaction phase (used only with the timeout feature); 8-bit counter range.
- ACLK  in  1  clock
- ARESETn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted this cycle when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  32  byte address
- cmd_wdata  in  32  write data
- cmd_wstrb  in  4  write byte strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  32  read data (0 for writes)
- rsp_resp  out  2  BRESP/RRESP, or SLVERR on timeout
- rsp_timeout  out  1  response produced by timeout
- AWVALID/AWREADY, AWADDR[31:0], AWPROT[2:0]  out/in/out/out: write address channel
- WVALID/WREADY, WDATA[31:0], WSTRB[3:0]  out/in/out/out: write data channel
- BVALID/BREADY, BRESP[1:0]  in/out/in: write response channel
- ARVALID/ARREADY, ARADDR[31:0], ARPROT[2:0]  out/in/out/out: read address channel
- RVALID/RREADY, RDATA[31:0], RRESP[1:0]  in/out/in/in: read data channel

## Operation
- All outputs are registered. AWPROT and ARPROT are constant 3'b000.
- FSM states and transitions:
  - IDLE: on cmd_valid & cmd_ready, latch addr, wdata, wstrb, and write. Go to W_ADDR_DAT if write, else R_ADDR.
  - W_ADDR_DAT: AWVALID and WVALID assert together. Each deasserts independently on its own handshake. Leave when both handshakes are done (same or different cycles); go to W_RESP.
  - W_RESP: BREADY=1. On BVALID, latch BRESP and set rsp_rdata=0. Go to RSP.
  - R_ADDR: ARVALID=1 until ARREADY. Then go to R_DATA.
  - R_DATA: RREADY=1. On RVALID, latch RDATA and RRESP. Go to RSP.
  - RSP: rsp_valid=1, with data held stable, until rsp_ready. Then go to IDLE.
- cmd_ready is high only in IDLE. One transaction is in flight at a time; no new command is accepted until the response is consumed.
- AW/W/AR address and data outputs hold stable while their VALID is high.
- BREADY and RREADY are low outside W_RESP/R_DATA. Stray BVALID/RVALID in other states is ignored.
- Reset values: every VALID/READY output is 0, including cmd_ready and rsp_valid. rsp_rdata, rsp_resp, rsp_timeout, and all address/data outputs are 0. FSM is in IDLE.
- Reset mid-transaction aborts immediately, with no response generated.

## Timing
- Command accepted at edge N → AWVALID/WVALID (or ARVALID) high after edge N.
- VALID drops on the edge where VALID & READY is sampled high.
- BVALID/RVALID sampled with the ready high at edge M → rsp_valid high after edge M.
- Minimum write latency (slave ready immediately): cmd accept → rsp_valid in 3 cycles. Read is the same.
- cmd_ready first rises one edge after ARESETn deasserts, and one edge after the rsp_valid & rsp_ready handshake.

## Configuration
- AXIL_MASTER_TIMEOUT_EN defined:
  - A counter clears on each state entry and increments every cycle spent in W_ADDR_DAT, W_RESP, R_ADDR, or R_DATA.
  - On reaching TIMEOUT_CYCLES, all AXI VALID/READY outputs drop next edge and the FSM goes to RSP with rsp_resp=2'b10 (SLVERR), rsp_timeout=1, rsp_rdata=0.
  - This is a debug recovery mechanism; it knowingly abandons the AXI transaction.
- Not defined: no counter; the block waits indefinitely and rsp_timeout is tied 0.

## Structure
- Shared package axi_lite_pkg holds:
  - response codes OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - master FSM state encoding (3 bits);
  - the default TIMEOUT_CYCLES constant.
- Sub-module axil_timeout_cnt (clear, enable, limit → expired) is instantiated only under AXIL_MASTER_TIMEOUT_EN.

## Test plan
- Write 0x000000A5 to 0x00, strobe 4'h1, slave ready immediately → AWADDR=0, WDATA=0xA5; rsp_resp=2'b00, rsp_rdata=0; slave LED register reads 0xA5.
- Read 0x28 → ARADDR=0x28; rsp_rdata=0x7E8155AA, rsp_resp=2'b00.
- Read 0x30 → rsp_resp=2'b11 (DECERR) passed through unchanged.
- Slave asserts AWREADY 2 cycles before WREADY → AWVALID drops alone; WVALID holds with WDATA stable; exactly one B handshake; rsp_resp=OKAY.
- rsp_ready held low 5 cycles after rsp_valid → rsp_valid and rsp_rdata stable; cmd_ready stays 0 until the handshake; next command accepted one edge later.
- With TIMEOUT_EN and TIMEOUT_CYCLES=16, ARREADY stuck 0 → ARVALID drops after 16 cycles; rsp_resp=2'b10, rsp_timeout=1.
- ARESETn pulsed low in W_RESP → all outputs 0 asynchronously; no response emitted; next command after reset completes normally.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, master FSM encoding and default timeout.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_W_ADDR_DAT = 3'd1,
    ST_W_RESP     = 3'd2,
    ST_R_ADDR     = 3'd3,
    ST_R_DATA     = 3'd4,
    ST_RSP        = 3'd5
  } mst_state_e;

endpackage

// File: rtl/axil_timeout_cnt.sv
// Per-phase wait-cycle counter for the AXI4-Lite master; only built with AXIL_MASTER_TIMEOUT_EN.
`ifdef AXIL_MASTER_TIMEOUT_EN
module axil_timeout_cnt (
  input  logic       ACLK,
  input  logic       ARESETn,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] limit,
  output logic       expired
);

  logic [7:0] cnt;

  // Fires during the limit-th enabled cycle so the abort lands on the following edge.
  assign expired = enable && (({1'b0, cnt} + 9'd1) >= {1'b0, limit});

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)                cnt <= '0;
    else if (clear)              cnt <= '0;
    else if (enable && !expired) cnt <= cnt + 8'd1;
  end

endmodule
`endif

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator driven by a valid/ready command port.
// Optional phase timeout recovery enabled by defining AXIL_MASTER_TIMEOUT_EN.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_timeout,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] AWADDR,
  output logic [2:0]  AWPROT,
  output logic        WVALID,
  input  logic        WREADY,
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  input  logic        BVALID,
  output logic        BREADY,
  input  logic [1:0]  BRESP,
  output logic        ARVALID,
  input  logic        ARREADY,
  output logic [31:0] ARADDR,
  output logic [2:0]  ARPROT,
  input  logic        RVALID,
  output logic        RREADY,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP
);

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  mst_state_e  state_q, state_d;
  logic        cmd_ready_d, rsp_valid_d, aw_valid_d, w_valid_d, b_ready_d, ar_valid_d, r_ready_d;
  logic [31:0] rsp_rdata_d, awaddr_d, wdata_d, araddr_d;
  logic [3:0]  wstrb_d;
  logic [1:0]  rsp_resp_d;
  logic        aw_done, w_done;

  assign AWPROT  = '0;
  assign ARPROT  = '0;
  assign aw_done = !AWVALID || AWREADY;
  assign w_done  = !WVALID  || WREADY;

`ifdef AXIL_MASTER_TIMEOUT_EN
  logic to_expired, rsp_timeout_d;

  axil_timeout_cnt u_timeout (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .clear   (state_d != state_q),
    .enable  (state_q inside {ST_W_ADDR_DAT, ST_W_RESP, ST_R_ADDR, ST_R_DATA}),
    .limit   (8'(TIMEOUT_CYCLES)),
    .expired (to_expired)
  );
`else
  assign rsp_timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_resp_d  = rsp_resp;
    aw_valid_d  = AWVALID;
    w_valid_d   = WVALID;
    b_ready_d   = BREADY;
    ar_valid_d  = ARVALID;
    r_ready_d   = RREADY;
    awaddr_d    = AWADDR;
    wdata_d     = WDATA;
    wstrb_d     = WSTRB;
    araddr_d    = ARADDR;
`ifdef AXIL_MASTER_TIMEOUT_EN
    rsp_timeout_d = rsp_timeout;
`endif
    unique case (state_q)
      ST_IDLE: if (cmd_valid && cmd_ready) begin
        if (cmd_write) begin
          awaddr_d   = cmd_addr;
          wdata_d    = cmd_wdata;
          wstrb_d    = cmd_wstrb;
          aw_valid_d = 1'b1;
          w_valid_d  = 1'b1;
          state_d    = ST_W_ADDR_DAT;
        end else begin
          araddr_d   = cmd_addr;
          ar_valid_d = 1'b1;
          state_d    = ST_R_ADDR;
        end
      end
      ST_W_ADDR_DAT: begin
        if (AWREADY) aw_valid_d = 1'b0;
        if (WREADY)  w_valid_d  = 1'b0;
        if (aw_done && w_done) begin
          b_ready_d = 1'b1;
          state_d   = ST_W_RESP;
        end
      end
      ST_W_RESP: if (BVALID) begin
        b_ready_d   = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
        rsp_resp_d  = BRESP;
        state_d     = ST_RSP;
      end
      ST_R_ADDR: if (ARREADY) begin
        ar_valid_d = 1'b0;
        r_ready_d  = 1'b1;
        state_d    = ST_R_DATA;
      end
      ST_R_DATA: if (RVALID) begin
        r_ready_d   = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = RDATA;
        rsp_resp_d  = RRESP;
        state_d     = ST_RSP;
      end
      ST_RSP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef AXIL_MASTER_TIMEOUT_EN
    if (state_d == ST_RSP && state_q != ST_RSP) rsp_timeout_d = 1'b0;
    // A phase that completes on the expiry edge keeps its real result; only a stalled phase aborts.
    if (to_expired && state_d == state_q) begin
      aw_valid_d    = 1'b0;
      w_valid_d     = 1'b0;
      b_ready_d     = 1'b0;
      ar_valid_d    = 1'b0;
      r_ready_d     = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_rdata_d   = '0;
      rsp_resp_d    = RESP_SLVERR;
      rsp_timeout_d = 1'b1;
      state_d       = ST_RSP;
    end
`endif
    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= ST_IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
      AWVALID   <= 1'b0;
      WVALID    <= 1'b0;
      BREADY    <= 1'b0;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
      AWADDR    <= '0;
      WDATA     <= '0;
      WSTRB     <= '0;
      ARADDR    <= '0;
    end else begin
      state_q   <= state_d;
      cmd_ready <= cmd_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_resp  <= rsp_resp_d;
      AWVALID   <= aw_valid_d;
      WVALID    <= w_valid_d;
      BREADY    <= b_ready_d;
      ARVALID   <= ar_valid_d;
      RREADY    <= r_ready_d;
      AWADDR    <= awaddr_d;
      WDATA     <= wdata_d;
      WSTRB     <= wstrb_d;
      ARADDR    <= araddr_d;
    end
  end

`ifdef AXIL_MASTER_TIMEOUT_EN
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) rsp_timeout <= 1'b0;
    else          rsp_timeout <= rsp_timeout_d;
  end
`endif

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: register-map slave model with programmable stalls, response scoreboard.
module tb_axi_lite_master;
  import axi_lite_pkg::*;

  logic        ACLK, ARESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [3:0]  WSTRB;
  logic [2:0]  AWPROT, ARPROT;
  logic [1:0]  BRESP, RRESP;

  axi_lite_master #(.TIMEOUT_CYCLES(16)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- slave model ----------------
  int unsigned aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0;
  int unsigned aw_cnt, w_cnt, ar_cnt, b_wait;
  logic        have_aw, have_w, b_busy;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;
  logic [31:0] led_reg = '0, scratch_reg = '0;
  int unsigned b_hs = 0;

  function automatic logic [1:0] decode(input logic [31:0] a);
    return (a == 32'h00 || a == 32'h04 || a == 32'h28) ? RESP_OKAY : RESP_DECERR;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rd(input logic [31:0] a);
    case (a)
      32'h00:  return led_reg;
      32'h04:  return scratch_reg;
      32'h28:  return 32'h7E8155AA;
      default: return 32'h0;
    endcase
  endfunction

  assign AWREADY = AWVALID && (aw_cnt >= aw_dly);
  assign WREADY  = WVALID  && (w_cnt  >= w_dly);
  assign ARREADY = ARVALID && (ar_cnt >= ar_dly);

  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_wait <= 0;
      have_aw <= 1'b0; have_w <= 1'b0; b_busy <= 1'b0;
      BVALID <= 1'b0; BRESP <= '0; RVALID <= 1'b0; RDATA <= '0; RRESP <= '0;
    end else begin
      aw_cnt <= (AWVALID && !AWREADY) ? aw_cnt + 1 : 0;
      w_cnt  <= (WVALID  && !WREADY)  ? w_cnt + 1  : 0;
      ar_cnt <= (ARVALID && !ARREADY) ? ar_cnt + 1 : 0;
      if (AWVALID && AWREADY) begin have_aw <= 1'b1; cap_awaddr <= AWADDR; end
      if (WVALID && WREADY) begin have_w <= 1'b1; cap_wdata <= WDATA; cap_wstrb <= WSTRB; end
      if (have_aw && have_w) begin
        have_aw <= 1'b0; have_w <= 1'b0;
        if (cap_awaddr == 32'h00) led_reg <= merge(led_reg, cap_wdata, cap_wstrb);
        if (cap_awaddr == 32'h04) scratch_reg <= merge(scratch_reg, cap_wdata, cap_wstrb);
        BRESP  <= decode(cap_awaddr);
        b_busy <= 1'b1;
        b_wait <= b_dly;
      end
      if (b_busy) begin
        if (b_wait == 0) begin BVALID <= 1'b1; b_busy <= 1'b0; end
        else b_wait <= b_wait - 1;
      end
      if (BVALID && BREADY) begin BVALID <= 1'b0; b_hs <= b_hs + 1; end
      if (ARVALID && ARREADY) begin
        RVALID <= 1'b1; RDATA <= rd(ARADDR); RRESP <= decode(ARADDR); cap_araddr <= ARADDR;
      end
      if (RVALID && RREADY) RVALID <= 1'b0;
    end
  end

  // ---------------- monitors ----------------
  int unsigned w_unstable = 0, w_alone = 0, ar_hi = 0;
  logic        w_pend = 1'b0;
  logic [31:0] w_prev = '0;
  always @(negedge ACLK) begin
    if (w_pend && WDATA !== w_prev) w_unstable++;
    w_pend = WVALID && !WREADY;
    w_prev = WDATA;
    if (!AWVALID && WVALID) w_alone++;
    if (ARVALID) ar_hi++;
  end

  // ---------------- scoreboard / drivers ----------------
  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        tmo;
  } exp_t;
  exp_t sb[$];

  task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [31:0] exp_rdata,
                        input logic [1:0] exp_resp, input bit exp_tmo, input bit push);
    int unsigned waited = 0;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; cmd_valid = 1'b1;
    while (!cmd_ready && waited < 100) begin @(negedge ACLK); waited++; end
    if (!cmd_ready) begin
      check("cmd_accept_wait", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    if (push) sb.push_back('{rdata: exp_rdata, resp: exp_resp, tmo: exp_tmo});
    @(negedge ACLK);
    cmd_valid = 1'b0;
    check("valids_after_accept", {AWVALID, WVALID, ARVALID}, wr ? 32'h6 : 32'h1);
    check("cmd_ready_after_accept", 32'(cmd_ready), 32'd0);
  endtask

  task automatic get_rsp(input int unsigned hold);
    int unsigned waited = 0;
    logic [31:0] held;
    exp_t e;
    while (!rsp_valid && waited < 200) begin @(negedge ACLK); waited++; end
    if (!rsp_valid) begin
      check("rsp_wait", 32'(rsp_valid), 32'd1);
      if (sb.size() != 0) void'(sb.pop_front());
      return;
    end
    held = rsp_rdata;
    for (int unsigned i = 0; i < hold; i++) begin
      @(negedge ACLK);
      check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
      check("rsp_hold_rdata", rsp_rdata, held);
      check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    end
    check("sb_size", sb.size(), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("rsp_rdata", rsp_rdata, e.rdata);
      check("rsp_resp", 32'(rsp_resp), 32'(e.resp));
      check("rsp_timeout", 32'(rsp_timeout), 32'(e.tmo));
    end
    rsp_ready = 1'b1;
    @(negedge ACLK);
    rsp_ready = 1'b0;
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    check("cmd_ready_return", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned b0, wa0, wu0, seen;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    ARESETn = 1'b1;
    #2 ARESETn = 1'b0;
    repeat (3) @(negedge ACLK);
    check("rst_handshakes", {cmd_ready, rsp_valid, AWVALID, WVALID, BREADY, ARVALID, RREADY}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_resp", {rsp_resp, rsp_timeout}, 32'd0);
    check("rst_addrs", AWADDR | ARADDR | WDATA | 32'(WSTRB) | 32'(AWPROT) | 32'(ARPROT), 32'd0);
    ARESETn = 1'b1;
    #1 check("cmd_ready_before_edge", 32'(cmd_ready), 32'd0);
    @(negedge ACLK);
    check("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);

    // LED write, byte strobe 0 only
    do_cmd(1'b1, 32'h00, 32'h000000A5, 4'h1, 32'h0, RESP_OKAY, 1'b0, 1'b1);
    get_rsp(0);
    check("cap_awaddr", cap_awaddr, 32'h00);
    check("cap_wdata", cap_wdata, 32'hA5);
    check("led_reg", led_reg, 32'hA5);
    do_cmd(1'b0, 32'h00, 32'h0, 4'h0, 32'hA5, RESP_OKAY, 1'b0, 1'b1);
    get_rsp(0);

    do_cmd(1'b0, 32'h28, 32'h0, 4'h0, 32'h7E8155AA, RESP_OKAY, 1'b0, 1'b1);
    get_rsp(0);
    check("cap_araddr", cap_araddr, 32'h28);
    do_cmd(1'b0, 32'h30, 32'h0, 4'h0, 32'h0, RESP_DECERR, 1'b0, 1'b1);
    get_rsp(0);
    do_cmd(1'b1, 32'h40, 32'h1, 4'hF, 32'h0, RESP_DECERR, 1'b0, 1'b1);
    get_rsp(0);

    // partial strobes merge into existing contents
    do_cmd(1'b1, 32'h04, 32'hFFFFFFFF, 4'hF, 32'h0, RESP_OKAY, 1'b0, 1'b1);
    get_rsp(0);
    do_cmd(1'b1, 32'h04, 32'h12345678, 4'b0110, 32'h0, RESP_OKAY, 1'b0, 1'b1);
    get_rsp(0);
    do_cmd(1'b0, 32'h04, 32'h0, 4'h0, 32'hFF3456FF, RESP_OKAY, 1'b0, 1'b1);
    get_rsp(0);

    // AWREADY two cycles ahead of WREADY
    b0 = b_hs; wa0 = w_alone; wu0 = w_unstable;
    aw_dly = 0; w_dly = 2;
    do_cmd(1'b1, 32'h04, 32'h0BADF00D, 4'hF, 32'h0, RESP_OKAY, 1'b0, 1'b1);
    get_rsp(0);
    check("w_alone_cycles", w_alone - wa0, 32'd2);
    check("wdata_stable", w_unstable - wu0, 32'd0);
    check("b_handshakes", b_hs - b0, 32'd1);
    check("scratch_after_split", scratch_reg, 32'h0BADF00D);

    // WREADY ahead of AWREADY, with response held back by the consumer
    aw_dly = 3; w_dly = 0; b_dly = 2;
    do_cmd(1'b1, 32'h00, 32'h5A5A5A5A, 4'hC, 32'h0, RESP_OKAY, 1'b0, 1'b1);
    get_rsp(5);
    aw_dly = 0; b_dly = 0; ar_dly = 2;
    do_cmd(1'b0, 32'h00, 32'h0, 4'h0, 32'h5A5A00A5, RESP_OKAY, 1'b0, 1'b1);
    get_rsp(5);
    ar_dly = 0;

`ifdef AXIL_MASTER_TIMEOUT_EN
    ar_dly = 32'hFFFF_FFFF;
    wu0 = ar_hi;
    do_cmd(1'b0, 32'h28, 32'h0, 4'h0, 32'h0, RESP_SLVERR, 1'b1, 1'b1);
    get_rsp(0);
    check("ar_valid_cycles", ar_hi - wu0, 32'd16);
    ar_dly = 0;
`endif

    // reset while waiting for BVALID
    b_dly = 30;
    do_cmd(1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 32'h0, RESP_OKAY, 1'b0, 1'b0);
    seen = 0;
    while (!BREADY && seen < 50) begin @(negedge ACLK); seen++; end
    check("bready_before_reset", 32'(BREADY), 32'd1);
    #2 ARESETn = 1'b0;
    #1;
    check("async_rst_handshakes", {cmd_ready, rsp_valid, AWVALID, WVALID, BREADY, ARVALID, RREADY}, 32'd0);
    check("async_rst_data", AWADDR | WDATA | 32'(WSTRB) | rsp_rdata | 32'(rsp_resp), 32'd0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    b_dly = 0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge ACLK);
      if (rsp_valid) seen++;
    end
    check("no_rsp_after_reset", seen, 32'd0);
    do_cmd(1'b1, 32'h04, 32'h0000CAFE, 4'hF, 32'h0, RESP_OKAY, 1'b0, 1'b1);
    get_rsp(0);
    do_cmd(1'b0, 32'h04, 32'h0, 4'h0, 32'h0000CAFE, RESP_OKAY, 1'b0, 1'b1);
    get_rsp(0);
    check("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
